// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: state encoding, key codes
// and the visible screen area used to qualify collisions.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam logic [7:0]  KEY_SPACE = 8'h2C;
  localparam logic [7:0]  KEY_ENTER = 8'h28;

  localparam logic [9:0]  SCREEN_W  = 10'd640;
  localparam logic [9:0]  SCREEN_H  = 10'd480;

  localparam logic [15:0] BCD_MAX   = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of
// rolling over so a long game never shows a wrapped score.
module bcd_counter4
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_bcd
);

  logic [3:0] w_carry;

  assign w_carry[0] = i_inc && (o_bcd != BCD_MAX);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] r_digit;

      assign o_bcd[gi*4 +: 4] = r_digit;

      // A digit advances only when every lower digit is rolling over from 9.
      if (gi < 3) begin : g_carry
        assign w_carry[gi+1] = w_carry[gi] && (r_digit == 4'd9);
      end

      always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
          r_digit <= 4'd0;
        end else if (w_carry[gi]) begin
          r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/game_ctrl.sv
// Game controller: per-frame collision detection between stickman and obstacle
// pixels, the IDLE/RUN/HIT/OVER state machine, lives, flash timer and score.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [1:0] LIVES        = 2'd3,
  parameter logic [7:0] COLL_THRESH  = 8'd8,
  parameter logic [7:0] FLASH_FRAMES = 8'd60,
  parameter logic [7:0] SCORE_DIV    = 8'd6,
  parameter logic [7:0] START_KEY    = KEY_SPACE,
  parameter logic [7:0] RESTART_KEY  = KEY_ENTER
)
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        is_stickman,
  input  logic        is_obstacle,
  output logic [1:0]  game_state,
  output logic        run_enable,
  output logic [15:0] score_bcd,
  output logic [1:0]  lives,
  output logic        flash,
  output logic        hit_pulse
);

  logic        r_fclk_q1, r_fclk_q2, r_frame_start;
  logic [7:0]  r_ovl_cnt;
  logic        w_overlap, w_frame_hit;

  game_state_t r_state, r_state_next;
  logic [1:0]  r_lives, r_lives_next;
  logic [7:0]  r_flash_timer, r_flash_timer_next;
  logic [7:0]  r_div, r_div_next;
  logic        r_hit_pulse, r_hit_pulse_next;
  logic        w_score_clr, w_score_inc, w_div_wrap;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fclk_q1     <= 1'b0;
      r_fclk_q2     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_fclk_q1     <= frame_clk;
      r_fclk_q2     <= r_fclk_q1;
      r_frame_start <= r_fclk_q1 & ~r_fclk_q2;
    end
  end

  assign w_overlap   = is_stickman && is_obstacle && (DrawX < SCREEN_W) && (DrawY < SCREEN_H);
  assign w_frame_hit = r_frame_start && (r_ovl_cnt >= COLL_THRESH);

  // The verdict uses last frame's count; an overlap on the tick opens the new frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ovl_cnt <= 8'd0;
    end else if (r_frame_start) begin
      r_ovl_cnt <= w_overlap ? 8'd1 : 8'd0;
    end else if (w_overlap && (r_ovl_cnt != 8'hFF)) begin
      r_ovl_cnt <= r_ovl_cnt + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_lives       <= LIVES;
      r_flash_timer <= 8'd0;
      r_div         <= 8'd0;
      r_hit_pulse   <= 1'b0;
    end else begin
      r_state       <= r_state_next;
      r_lives       <= r_lives_next;
      r_flash_timer <= r_flash_timer_next;
      r_div         <= r_div_next;
      r_hit_pulse   <= r_hit_pulse_next;
    end
  end

  assign w_div_wrap = (r_div == SCORE_DIV - 8'd1);

  always_comb begin
    r_state_next       = r_state;
    r_lives_next       = r_lives;
    r_flash_timer_next = r_flash_timer;
    r_div_next         = r_div;
    r_hit_pulse_next   = 1'b0;
    w_score_clr        = 1'b0;
    w_score_inc        = 1'b0;

    case (r_state)
      IDLE: begin
        if (keycode == START_KEY) begin
          r_state_next = RUN;
          r_lives_next = LIVES;
          r_div_next   = 8'd0;
          w_score_clr  = 1'b1;
        end
      end
      RUN: begin
        if (w_frame_hit) begin
          r_hit_pulse_next = 1'b1;
          if (r_lives <= 2'd1) begin
            r_state_next = OVER;
            r_lives_next = 2'd0;
          end else begin
            r_state_next       = HIT;
            r_lives_next       = r_lives - 2'd1;
            r_flash_timer_next = 8'd0;
          end
        end else if (r_frame_start) begin
          r_div_next  = w_div_wrap ? 8'd0 : r_div + 8'd1;
          w_score_inc = w_div_wrap;
        end
      end
      HIT: begin
        if (r_frame_start) begin
          r_div_next  = w_div_wrap ? 8'd0 : r_div + 8'd1;
          w_score_inc = w_div_wrap;
          if (r_flash_timer == FLASH_FRAMES - 8'd1) begin
            r_state_next       = RUN;
            r_flash_timer_next = 8'd0;
          end else begin
            r_flash_timer_next = r_flash_timer + 8'd1;
          end
        end
      end
      OVER: begin
        if (keycode == RESTART_KEY) begin
          r_state_next = IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  bcd_counter4 u_score (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (w_score_clr),
    .i_inc (w_score_inc),
    .o_bcd (score_bcd)
  );

  assign game_state = r_state;
  assign run_enable = (r_state == RUN) || (r_state == HIT);
  assign lives      = r_lives;
  assign flash      = (r_state == HIT) && r_flash_timer[3];
  assign hit_pulse  = r_hit_pulse;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expectations are queued as stimulus is applied
// and compared against the outputs on the falling clock edge.
module tb_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, is_stickman, is_obstacle;
  logic [7:0]  keycode;
  logic [9:0]  DrawX, DrawY;
  logic [1:0]  game_state, lives;
  logic        run_enable, flash, hit_pulse;
  logic [15:0] score_bcd;

  logic        b_clr, b_inc;
  logic [15:0] b_out;

  always #10 Clk = ~Clk;

  game_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .is_stickman (is_stickman),
    .is_obstacle (is_obstacle),
    .game_state  (game_state),
    .run_enable  (run_enable),
    .score_bcd   (score_bcd),
    .lives       (lives),
    .flash       (flash),
    .hit_pulse   (hit_pulse)
  );

  bcd_counter4 u_bcd (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (b_clr),
    .i_inc (b_inc),
    .o_bcd (b_out)
  );

  localparam int S_STATE = 0, S_LIVES = 1, S_SCORE = 2, S_RUN = 3,
                 S_FLASH = 4, S_HITS = 5, S_BCD = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   hits_seen = 0;
  int   exp_score = 0;
  int   exp_div = 0;

  always @(posedge Clk) begin
    if (hit_pulse === 1'b1) hits_seen++;
  end

  function automatic logic [15:0] to_bcd(input int s);
    return 16'(((s / 1000) % 10) << 12 | ((s / 100) % 10) << 8 | ((s / 10) % 10) << 4 | (s % 10));
  endfunction

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_STATE: return {14'd0, game_state};
      S_LIVES: return {14'd0, lives};
      S_SCORE: return score_bcd;
      S_RUN:   return {15'd0, run_enable};
      S_FLASH: return {15'd0, flash};
      S_HITS:  return 16'(hits_seen);
      default: return b_out;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
      $display("check %-14s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic frame(input bit scoring);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    if (scoring) begin
      if (exp_div == 5) begin
        exp_div = 0;
        if (exp_score < 9999) exp_score++;
      end else begin
        exp_div++;
      end
    end
  endtask

  task automatic overlap(input int n, input logic [9:0] x);
    @(negedge Clk);
    is_stickman = 1'b1; is_obstacle = 1'b1; DrawX = x; DrawY = 10'd100;
    repeat (n) @(negedge Clk);
    is_stickman = 1'b0; is_obstacle = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    @(negedge Clk) keycode = 8'h00;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; DrawX = 10'd0; DrawY = 10'd0;
    is_stickman = 1'b0; is_obstacle = 1'b0; b_clr = 1'b0; b_inc = 1'b0;
    repeat (3) @(negedge Clk);
    push("rst_state", S_STATE, 16'd0); push("rst_lives", S_LIVES, 16'd3);
    push("rst_score", S_SCORE, 16'h0000); push("rst_run", S_RUN, 16'd0);
    push("rst_flash", S_FLASH, 16'd0); push("rst_hits", S_HITS, 16'd0);
    check_all();
    Reset = 1'b0;

    press(8'h2C);
    exp_score = 0; exp_div = 0;
    push("start_state", S_STATE, 16'd1); push("start_lives", S_LIVES, 16'd3);
    push("start_score", S_SCORE, 16'h0000); push("start_run", S_RUN, 16'd1);
    check_all();

    repeat (60) frame(1'b1);
    push("score_60f", S_SCORE, to_bcd(exp_score)); push("no_hit_60f", S_HITS, 16'd0);
    check_all();

    overlap(7, 10'd100); frame(1'b1);
    push("ovl7_state", S_STATE, 16'd1); push("ovl7_lives", S_LIVES, 16'd3);
    push("ovl7_hits", S_HITS, 16'd0);
    check_all();

    overlap(10, 10'd700); frame(1'b1);
    push("offscr_hits", S_HITS, 16'd0); push("offscr_lives", S_LIVES, 16'd3);
    check_all();

    overlap(8, 10'd100); frame(1'b0);
    push("hit1_pulse", S_HITS, 16'd1); push("hit1_lives", S_LIVES, 16'd2);
    push("hit1_state", S_STATE, 16'd2); push("hit1_flash", S_FLASH, 16'd0);
    push("hit1_score", S_SCORE, to_bcd(exp_score));
    check_all();

    for (int k = 1; k <= 60; k++) begin
      if (k == 1) overlap(20, 10'd100);
      frame(1'b1);
      if (k == 1) begin
        push("hit_ign_lives", S_LIVES, 16'd2); push("hit_ign_state", S_STATE, 16'd2);
        push("hit_ign_hits", S_HITS, 16'd1);
      end
      if (k < 60) push($sformatf("flash_f%0d", k), S_FLASH, 16'((k >> 3) & 1));
      else begin
        push("hit_end_state", S_STATE, 16'd1); push("hit_end_flash", S_FLASH, 16'd0);
      end
      check_all();
    end
    push("hit_score", S_SCORE, to_bcd(exp_score));
    check_all();

    overlap(8, 10'd100); frame(1'b0);
    push("hit2_lives", S_LIVES, 16'd1); push("hit2_hits", S_HITS, 16'd2);
    check_all();
    repeat (60) frame(1'b1);
    push("hit2_end", S_STATE, 16'd1);
    check_all();

    overlap(8, 10'd100); frame(1'b0);
    push("over_state", S_STATE, 16'd3); push("over_lives", S_LIVES, 16'd0);
    push("over_run", S_RUN, 16'd0); push("over_hits", S_HITS, 16'd3);
    check_all();
    repeat (10) frame(1'b0);
    push("over_frozen", S_SCORE, to_bcd(exp_score)); push("over_stay", S_STATE, 16'd3);
    check_all();

    press(8'h28);
    push("idle_state", S_STATE, 16'd0); push("idle_score", S_SCORE, to_bcd(exp_score));
    push("idle_run", S_RUN, 16'd0);
    check_all();

    // Start key lands on the same cycle as the frame tick, with a pending overlap.
    overlap(10, 10'd100);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    keycode = 8'h2C;
    @(negedge Clk) keycode = 8'h00;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    exp_score = 0; exp_div = 0;
    push("sim_state", S_STATE, 16'd1); push("sim_lives", S_LIVES, 16'd3);
    push("sim_score", S_SCORE, 16'h0000); push("sim_hits", S_HITS, 16'd3);
    check_all();
    repeat (6) frame(1'b1);
    push("sim_nohit", S_HITS, 16'd3); push("sim_score6", S_SCORE, to_bcd(exp_score));
    check_all();

    overlap(8, 10'd100); frame(1'b0);
    repeat (8) frame(1'b1);
    push("pre_rst_state", S_STATE, 16'd2); push("pre_rst_flash", S_FLASH, 16'd1);
    check_all();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    push("mid_rst_state", S_STATE, 16'd0); push("mid_rst_score", S_SCORE, 16'h0000);
    push("mid_rst_flash", S_FLASH, 16'd0); push("mid_rst_lives", S_LIVES, 16'd3);
    check_all();
    Reset = 1'b0;

    @(negedge Clk) b_inc = 1'b1;
    repeat (1234) @(negedge Clk);
    b_inc = 1'b0;
    push("bcd_1234", S_BCD, 16'h1234);
    check_all();
    b_inc = 1'b1;
    repeat (9999 - 1234) @(negedge Clk);
    b_inc = 1'b0;
    push("bcd_9999", S_BCD, 16'h9999);
    check_all();
    b_inc = 1'b1;
    repeat (5) @(negedge Clk);
    b_inc = 1'b0;
    push("bcd_sat", S_BCD, 16'h9999);
    check_all();
    b_clr = 1'b1; b_inc = 1'b1;
    @(negedge Clk) b_clr = 1'b0; b_inc = 1'b0;
    push("bcd_clr", S_BCD, 16'h0000);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Downstream consumer of the stickman shape stage (`is_stickman`) and the obstacle shape stage (`is_obstacle`).
- Detects pixel overlap during each video frame and runs the game state machine (IDLE/RUN/HIT/OVER).
- Keeps a 4-digit BCD score and a lives counter.
- Drives `run_enable` to the motion stages and the score/lives/flash outputs to the color mapper.

Parameters:
- LIVES, 3, lives loaded on game start (1..3).
- COLL_THRESH, 8, overlapping Clk cycles per frame needed to declare a hit (filters edge jitter).
- FLASH_FRAMES, 60, invulnerability length after a non-fatal hit, in frames.
- SCORE_DIV, 6, frames per score increment.
- START_KEY, 8'h2C, keycode that starts a game from IDLE (space).
- RESTART_KEY, 8'h28, keycode that returns from OVER to IDLE (enter).

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  ~60 Hz frame indicator (vsync-derived)
- keycode  in  8  last received key
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- is_stickman  in  1  pixel belongs to stickman
- is_obstacle  in  1  pixel belongs to an obstacle
- game_state  out  2  current state, encoding from game_pkg
- run_enable  out  1  high in RUN and HIT; gates motion/scroll stages
- score_bcd  out  16  4 BCD digits, [3:0] = units
- lives  out  2  remaining lives
- flash  out  1  stickman blink enable, HIT state only
- hit_pulse  out  1  one-Clk pulse per registered hit

Behaviour:
- Reset (sync, active-high, priority over all else): state=IDLE, score_bcd=0, lives=LIVES, flash=0, hit_pulse=0, run_enable=0; all internal counters=0.
- Frame tick:
  - Two-flop edge detect on frame_clk yields `frame_start`, a one-Clk pulse registered one cycle after the Clk that samples the rising edge.
  - All per-frame actions below happen on `frame_start` only.
- Overlap counter:
  - 8-bit, saturating at 255.
  - Increments each Clk where is_stickman && is_obstacle && DrawX<640 && DrawY<480.
  - On `frame_start`: frame_hit = (cnt >= COLL_THRESH), evaluated combinationally from the old count; cnt is cleared to 0.
  - An overlap in the same cycle as `frame_start` counts toward the new frame (cnt=1).
- State machine:
  - IDLE:
    - run_enable=0; score held.
    - keycode==START_KEY in any cycle -> RUN, same edge: score=0, lives=LIVES, frame divider=0.
  - RUN, on `frame_start`:
    - If frame_hit: hit_pulse=1 for that cycle; lives decrements.
      - Prior lives==1 -> OVER, lives=0.
      - Otherwise -> HIT, flash timer=0.
    - If not frame_hit: advance score divider; increment score when the divider reaches SCORE_DIV-1, then wrap the divider to 0.
  - HIT:
    - Collisions ignored; scoring continues exactly as in RUN.
    - Flash timer increments per frame; flash = timer[3] (toggles every 8 frames).
    - Timer == FLASH_FRAMES-1 on `frame_start` -> RUN, flash=0.
  - OVER:
    - run_enable=0; score and lives frozen.
    - keycode==RESTART_KEY -> IDLE; score is kept for display until the next start.
- Score arithmetic:
  - BCD ripple: a digit at 9 wraps to 0 and carries.
  - Saturates at 9999; no wrap to 0000.
- Simultaneous events:
  - START_KEY in the same cycle as `frame_start` in IDLE: enter RUN; no score or collision action that frame.
  - A hit in RUN takes precedence over the score increment in the same frame; that frame is not scored.
- Key handling: keys are level-sensitive. A held START_KEY after OVER->IDLE restarts immediately; this is intended.

Decomposition:
- game_pkg holds:
  - typedef enum logic [1:0] game_state_t {IDLE=0, RUN=1, HIT=2, OVER=3};
  - key constants KEY_SPACE=8'h2C, KEY_ENTER=8'h28;
  - SCREEN_W=640, SCREEN_H=480.
- One sub-module, bcd_counter4: synchronous clear, increment enable, saturate at 9999, 16-bit output.

Test Plan:
- Reset, then keycode=8'h2C for 1 Clk -> game_state=RUN, lives=3, score_bcd=16'h0000, run_enable=1.
- RUN, no overlap, 60 frames -> score_bcd=16'h0010; hit_pulse never asserted.
- Overlap of 8 Clk in one frame -> at next `frame_start`: hit_pulse one cycle, lives=2, state=HIT, flash toggles every 8 frames. After 60 frames -> RUN, flash=0. A 7-Clk overlap causes no hit.
- Overlap during HIT -> ignored, lives unchanged. Three hits in RUN -> lives=0, state=OVER, run_enable=0, score frozen over 10 further frames.
- OVER, keycode=8'h28 -> IDLE with score retained; then 8'h2C -> score_bcd=0, lives=3.
- Force score to 16'h9999 -> further increments hold 9999. Reset asserted mid-HIT -> next cycle IDLE, score 0, flash 0, lives 3.
